// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO ownership (MIPS MULT/MULTU/DIV/DIVU, MTHI/MTLO).
// Handshake: Start is accepted only in IDLE or DONE; Busy covers CALC and FIX; Done pulses for exactly one cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             HiWrite,
  input  logic             LoWrite,
  input  logic [WIDTH-1:0] WriteData,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic [1:0]       StateDbg
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]      count;
  logic               op_div;
  logic               neg_p;
  logic               neg_r;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;

  logic               accept;
  logic               is_div_in;
  logic               signed_in;
  logic               div_zero_in;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   quo_neg;
  logic [WIDTH-1:0]   rem_neg;

  assign accept      = Start && (state == IDLE || state == DONE);
  assign is_div_in   = Op[1];
  assign signed_in   = ~Op[0];
  assign div_zero_in = is_div_in && (B == '0);
  assign mag_a       = (signed_in && A[WIDTH-1]) ? -A : A;
  assign mag_b       = (signed_in && B[WIDTH-1]) ? -B : B;

  assign Busy     = (state == CALC) || (state == FIX);
  assign Done     = (state == DONE);
  assign StateDbg = state;

  // Multiply: acc = {partial product, remaining multiplier bits}, opnd = multiplicand.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Divide: acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
  assign div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = div_trial - {1'b0, opnd};
  assign div_next  = {(div_diff[WIDTH] ? div_trial[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                      acc[WIDTH-2:0], ~div_diff[WIDTH]};

  assign prod_neg = -acc;
  assign quo_neg  = -acc[WIDTH-1:0];
  assign rem_neg  = -acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (Start) state_nxt = div_zero_in ? DONE : CALC;
        else       state_nxt = IDLE;
      end
      CALC:    if (count == CW'(1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count   <= '0;
      op_div  <= 1'b0;
      neg_p   <= 1'b0;
      neg_r   <= 1'b0;
      opnd    <= '0;
      acc     <= '0;
      DivZero <= 1'b0;
      Hi      <= '0;
      Lo      <= '0;
    end else begin
      // Register writes land before a coincident Start; the later result overwrites them.
      if (!Busy) begin
        if (HiWrite) Hi <= WriteData;
        if (LoWrite) Lo <= WriteData;
      end
      if (accept) begin
        op_div  <= is_div_in;
        neg_p   <= signed_in && (A[WIDTH-1] ^ B[WIDTH-1]);
        neg_r   <= signed_in && A[WIDTH-1];
        DivZero <= div_zero_in;
        count   <= CW'(WIDTH);
        opnd    <= is_div_in ? mag_b : mag_a;
        acc     <= {{WIDTH{1'b0}}, (is_div_in ? mag_a : mag_b)};
      end
      if (state == CALC) begin
        count <= count - CW'(1);
        acc   <= op_div ? div_next : mul_next;
      end
      if (state == FIX) begin
        if (op_div) begin
          Lo <= neg_p ? quo_neg : acc[WIDTH-1:0];
          Hi <= neg_r ? rem_neg : acc[2*WIDTH-1:WIDTH];
        end else begin
          Hi <= neg_p ? prod_neg[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
          Lo <= neg_p ? prod_neg[WIDTH-1:0]       : acc[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed vectors checked with immediate assertions.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mult_div_unit;

  localparam int W = 32;
  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         hi_write, lo_write;
  logic [W-1:0] write_data;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;
  logic [1:0]   state_dbg;

  int vectors = 0;
  int miscompares = 0;
  int cyc, busy_cyc;

  mult_div_unit #(.WIDTH(W)) dut (
    .Clk(clk), .Reset(reset), .Start(start), .Op(op), .A(a), .B(b),
    .HiWrite(hi_write), .LoWrite(lo_write), .WriteData(write_data),
    .Busy(busy), .Done(done), .DivZero(div_zero), .Hi(hi), .Lo(lo),
    .StateDbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Present an operation for one edge (e0), then return at the following falling edge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
  endtask

  // Wait (bounded) for Done, counting cycles and Busy cycles seen on the way.
  task automatic wait_done(input string tag, output int cycles, output int busy_cycles);
    cycles = 0; busy_cycles = 0;
    while (done !== 1'b1 && cycles < 100) begin
      if (busy === 1'b1) busy_cycles++;
      cycles++;
      @(negedge clk);
    end
    check({tag, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic reg_write(input logic hw, input logic lw, input logic [W-1:0] d);
    hi_write = hw; lo_write = lw; write_data = d;
    @(negedge clk);
    hi_write = 1'b0; lo_write = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    hi_write = 1'b0; lo_write = 1'b0; write_data = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_divzero", 64'(div_zero), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: MULT -3 * 7, latency and pulse width
    issue(OP_MULT, 32'hFFFFFFFD, 32'h00000007);
    wait_done("t1", cyc, busy_cyc);
    check("t1_cycles", 64'(cyc), 64'd33);
    check("t1_busy_cycles", 64'(busy_cyc), 64'd33);
    check("t1_hi", 64'(hi), 64'hFFFFFFFF);
    check("t1_lo", 64'(lo), 64'hFFFFFFEB);
    @(negedge clk);
    check("t1_done_pulse", 64'(done), 64'd0);
    check("t1_idle", 64'(state_dbg), 64'd0);

    // 2: MULTU max*max, then back-to-back MULTU 3*5 issued in the Done cycle
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("t2a", cyc, busy_cyc);
    check("t2a_hi", 64'(hi), 64'hFFFFFFFE);
    check("t2a_lo", 64'(lo), 64'h00000001);
    issue(OP_MULTU, 32'd3, 32'd5);
    check("t2b_accepted", 64'(busy), 64'd1);
    check("t2b_done_low", 64'(done), 64'd0);
    wait_done("t2b", cyc, busy_cyc);
    check("t2b_cycles", 64'(cyc), 64'd33);
    check("t2b_hi", 64'(hi), 64'h0);
    check("t2b_lo", 64'(lo), 64'h0000000F);

    // 3: signed and unsigned divides
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done("t3a", cyc, busy_cyc);
    check("t3a_lo", 64'(lo), 64'hFFFFFFFD);
    check("t3a_hi", 64'(hi), 64'hFFFFFFFF);
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_done("t3b", cyc, busy_cyc);
    check("t3b_lo", 64'(lo), 64'h0000000E);
    check("t3b_hi", 64'(hi), 64'h00000002);
    issue(OP_DIV, 32'd7, 32'hFFFFFFFE);
    wait_done("t3c", cyc, busy_cyc);
    check("t3c_lo", 64'(lo), 64'hFFFFFFFD);
    check("t3c_hi", 64'(hi), 64'h00000001);
    issue(OP_MULT, 32'h80000000, 32'h80000000);
    wait_done("t3d", cyc, busy_cyc);
    check("t3d_hi", 64'(hi), 64'h40000000);
    check("t3d_lo", 64'(lo), 64'h00000000);

    // 4: divide by zero with preloaded Hi/Lo
    @(negedge clk);
    reg_write(1'b1, 1'b0, 32'h11111111);
    reg_write(1'b0, 1'b1, 32'h22222222);
    check("t4_mthi", 64'(hi), 64'h11111111);
    check("t4_mtlo", 64'(lo), 64'h22222222);
    issue(OP_DIV, 32'd5, 32'd0);
    check("t4_done_now", 64'(done), 64'd1);
    check("t4_busy", 64'(busy), 64'd0);
    check("t4_divzero", 64'(div_zero), 64'd1);
    check("t4_hi", 64'(hi), 64'h11111111);
    check("t4_lo", 64'(lo), 64'h22222222);
    @(negedge clk);
    check("t4_done_pulse", 64'(done), 64'd0);
    check("t4_divzero_hold", 64'(div_zero), 64'd1);
    issue(OP_MULT, 32'd6, 32'd7);
    check("t4_divzero_clr", 64'(div_zero), 64'd0);
    wait_done("t4b", cyc, busy_cyc);
    check("t4b_lo", 64'(lo), 64'd42);
    check("t4b_hi", 64'(hi), 64'd0);

    // 5: most-negative / -1 wraps without a flag
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done("t5", cyc, busy_cyc);
    check("t5_lo", 64'(lo), 64'h80000000);
    check("t5_hi", 64'(hi), 64'h00000000);
    check("t5_divzero", 64'(div_zero), 64'd0);

    // 6: Start and HiWrite ignored in CALC, then reset mid-operation
    issue(OP_MULTU, 32'd2, 32'd3);
    repeat (3) @(negedge clk);
    start = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd0;
    hi_write = 1'b1; write_data = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0; hi_write = 1'b0;
    check("t6_still_busy", 64'(busy), 64'd1);
    check("t6_still_calc", 64'(state_dbg), 64'd1);
    check("t6_hi_ignored", 64'(hi), 64'h00000000);
    check("t6_divzero", 64'(div_zero), 64'd0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_done", 64'(done), 64'd0);
    check("t6_rst_hi", 64'(hi), 64'd0);
    check("t6_rst_lo", 64'(lo), 64'd0);
    reg_write(1'b0, 1'b1, 32'h12345678);
    check("t6_mtlo", 64'(lo), 64'h12345678);
    check("t6_hi_kept", 64'(hi), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
